// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module div_iter #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  div_en,
  input  logic [2:0]            div_opcode,
  input  logic [WORD_WIDTH-1:0] div_data1,
  input  logic [WORD_WIDTH-1:0] div_data2,
  input  logic [TAG_WIDTH-1:0]  div_tag_in,
  input  logic                  div_flush,
  output logic                  div_busy,
  output logic [WORD_WIDTH-1:0] div_result,
  output logic                  div_result_valid,
  output logic [TAG_WIDTH-1:0]  div_tag_out
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    signed_q, signed_d;
  logic                    rem_sel_q, rem_sel_d;
  logic                    sign1_q, sign1_d;
  logic                    sign2_q, sign2_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [WORD_WIDTH-1:0]   rem_q, rem_d;
  logic [WORD_WIDTH-1:0]   quo_q, quo_d;
  logic [WORD_WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic [WORD_WIDTH-1:0]   result_q, result_d;
  logic                    valid_q, valid_d;
  logic [TAG_WIDTH-1:0]    tag_out_q, tag_out_d;

  logic                    signed_in;
  logic                    rem_in;
  logic [WORD_WIDTH-1:0]   mag1;
  logic [WORD_WIDTH-1:0]   mag2;
  logic [WORD_WIDTH:0]     shifted;
  logic [WORD_WIDTH:0]     trial;
  logic                    neg_quo;
  logic                    neg_rem;

`ifdef DIV_EARLY_OUT_EN
  localparam logic [WORD_WIDTH-1:0] ALL_ONES = {WORD_WIDTH{1'b1}};
  localparam logic [WORD_WIDTH-1:0] MIN_NEG  = {1'b1, {(WORD_WIDTH-1){1'b0}}};
`endif

  // Operand decode and magnitudes; anything outside the four M codes falls back to DIVU.
  always_comb begin
    signed_in = (div_opcode == 3'b100) || (div_opcode == 3'b110);
    rem_in    = (div_opcode == 3'b110) || (div_opcode == 3'b111);
    mag1      = (signed_in && div_data1[WORD_WIDTH-1]) ? -div_data1 : div_data1;
    mag2      = (signed_in && div_data2[WORD_WIDTH-1]) ? -div_data2 : div_data2;
    shifted   = {rem_q, quo_q[WORD_WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    neg_quo   = signed_q && (sign1_q != sign2_q) && (dvs_q != '0);
    neg_rem   = signed_q && sign1_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    signed_d  = signed_q;
    rem_sel_d = rem_sel_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    tag_d     = tag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (div_en) begin
          signed_d  = signed_in;
          rem_sel_d = rem_in;
          sign1_d   = div_data1[WORD_WIDTH-1];
          sign2_d   = div_data2[WORD_WIDTH-1];
          tag_d     = div_tag_in;
          rem_d     = '0;
          quo_d     = mag1;
          dvs_d     = mag2;
          cnt_d     = CNT_W'(WORD_WIDTH);
          state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          // Results the iteration would converge to anyway; go straight to sign fix-up.
          if (div_data2 == '0) begin
            quo_d   = ALL_ONES;
            rem_d   = mag1;
            state_d = S_FIX;
          end else if (signed_in && (div_data1 == MIN_NEG) && (div_data2 == ALL_ONES)) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        quo_d = {quo_q[WORD_WIDTH-2:0], ~trial[WORD_WIDTH]};
        rem_d = trial[WORD_WIDTH] ? shifted[WORD_WIDTH-1:0] : trial[WORD_WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (rem_sel_q) begin
          result_d = neg_rem ? -rem_q : rem_q;
        end else begin
          result_d = neg_quo ? -quo_q : quo_q;
        end
        tag_out_d = tag_q;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle accept or fix-up.
    if (div_flush) begin
      state_d   = S_IDLE;
      result_d  = result_q;
      tag_out_d = tag_out_q;
    end
  end

  always_comb begin
    busy_d  = (state_d == S_CALC) || (state_d == S_FIX);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      signed_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      tag_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      signed_q  <= signed_d;
      rem_sel_q <= rem_sel_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      tag_q     <= tag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign div_busy         = busy_q;
  assign div_result       = result_q;
  assign div_result_valid = valid_q;
  assign div_tag_out      = tag_out_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (32-bit operands, 6-bit tag).
module tb_div_iter;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_en = 1'b0;
  logic [2:0]  div_opcode = 3'b000;
  logic [31:0] div_data1 = '0;
  logic [31:0] div_data2 = '0;
  logic [5:0]  div_tag_in = '0;
  logic        div_flush = 1'b0;
  logic        div_busy;
  logic [31:0] div_result;
  logic        div_result_valid;
  logic [5:0]  div_tag_out;

  int total = 0;
  int bad = 0;

  div_iter #(.WORD_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .div_en           (div_en),
    .div_opcode       (div_opcode),
    .div_data1        (div_data1),
    .div_data2        (div_data2),
    .div_tag_in       (div_tag_in),
    .div_flush        (div_flush),
    .div_busy         (div_busy),
    .div_result       (div_result),
    .div_result_valid (div_result_valid),
    .div_tag_out      (div_tag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive one request; returns #1 into the first cycle after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    @(negedge clk);
    div_en = 1'b1; div_opcode = op; div_data1 = a; div_data2 = b; div_tag_in = tag;
    @(posedge clk);
    #1;
    div_en = 1'b0;
  endtask

  // Counts cycles since accept until valid (cycle 1 = first after accept), bounded.
  task automatic wait_valid(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (!div_result_valid && cyc < 100) begin
      if (!div_busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    bit bok;
    issue(op, a, b, 6'd1);
    wait_valid(cyc, bok);
    chk({name, "_res"}, div_result, exp);
    chk({name, "_lat"}, cyc, exp_lat);
  endtask

  initial begin
    int cyc;
    int n;
    bit bok;

    #1;
    chk("rst_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_res", div_result, 32'd0);
    chk("rst_valid", {31'd0, div_result_valid}, 32'd0);
    chk("rst_tag", {26'd0, div_tag_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // DIVU 100/7 with tag 5, latency and busy window
    issue(OP_DIVU, 32'd100, 32'd7, 6'd5);
    wait_valid(cyc, bok);
    chk("divu_res", div_result, 32'd14);
    chk("divu_tag", {26'd0, div_tag_out}, 32'd5);
    chk("divu_lat", cyc, 32'd34);
    chk("divu_busy", {31'd0, bok}, 32'd1);
    chk("divu_busy_done", {31'd0, div_busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("pulse_low", {31'd0, div_result_valid}, 32'd0);
    chk("hold_res", div_result, 32'd14);
    chk("hold_tag", {26'd0, div_tag_out}, 32'd5);

    // Back-to-back: REM issued in the DONE cycle of DIV
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd10);
    wait_valid(cyc, bok);
    chk("b2b_div_res", div_result, 32'hFFFF_FFFD);
    chk("b2b_div_tag", {26'd0, div_tag_out}, 32'd10);
    div_en = 1'b1; div_opcode = OP_REM; div_data1 = 32'hFFFF_FFF9; div_data2 = 32'd2;
    div_tag_in = 6'd11;
    @(posedge clk);
    #1;
    div_en = 1'b0;
    wait_valid(cyc, bok);
    chk("b2b_rem_res", div_result, 32'hFFFF_FFFF);
    chk("b2b_rem_tag", {26'd0, div_tag_out}, 32'd11);
    chk("b2b_rem_lat", cyc, 32'd34);

    run("ovf_div", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT);
    run("ovf_rem", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, EARLY_LAT);
    run("dz_div", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
    run("dz_divu", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
    run("dz_remu", OP_REMU, 32'd9, 32'd0, 32'd9, EARLY_LAT);
    run("dz_rem", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EARLY_LAT);
    run("div_pn", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run("rem_pn", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run("div_nn", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34);
    run("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    run("op_other", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34);
    run("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 34);

    // Flush in CALC cycle 10 of DIVU 50/5
    issue(OP_DIVU, 32'd50, 32'd5, 6'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    div_flush = 1'b0;
    chk("flush_busy", {31'd0, div_busy}, 32'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_result_valid) n++;
    end
    chk("flush_novalid", n, 32'd0);
    chk("flush_res_kept", div_result, 32'd1);
    run("post_flush", OP_DIVU, 32'd8, 32'd2, 32'd4, 34);

    // Asynchronous reset in cycle 20
    issue(OP_DIVU, 32'd100, 32'd7, 6'd9);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, div_busy}, 32'd0);
    chk("mid_rst_res", div_result, 32'd0);
    chk("mid_rst_valid", {31'd0, div_result_valid}, 32'd0);
    chk("mid_rst_tag", {26'd0, div_tag_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_result_valid) n++;
    end
    chk("rst_novalid", n, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
